// File: rtl/pipelined_alu_unit_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipelined_alu_unit_pkg : op encoding and shared helpers for the ALU   |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package pipelined_alu_unit_pkg;

   localparam int c_alu_latency = 2;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_XOR  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_AND  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } alu_op_t;

   // Compares are resolved from the subtract carry chain.
   function automatic logic alu_op_uses_sub(input alu_op_t op);
      return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_alu_unit_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipelined_alu_unit_if : issue and writeback handshake bundle          |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
interface pipelined_alu_unit_if
   import pipelined_alu_unit_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int ID_W = 3
);
   localparam int c_shamt_w = $clog2(XLEN);

   logic                 issue_valid;
   logic                 issue_ready;
   logic [ID_W-1:0]      issue_id;
   alu_op_t              op;
   logic [XLEN-1:0]      in1;
   logic [XLEN-1:0]      in2;
   logic [c_shamt_w-1:0] shamt;
   logic                 flush;
   logic                 wb_done;
   logic                 wb_ack;
   logic [ID_W-1:0]      wb_id;
   logic [XLEN-1:0]      wb_rd;
   logic                 busy;

   modport master (
      output issue_valid, issue_id, op, in1, in2, shamt, flush, wb_ack,
      input  issue_ready, wb_done, wb_id, wb_rd, busy
   );

   modport slave (
      input  issue_valid, issue_id, op, in1, in2, shamt, flush, wb_ack,
      output issue_ready, wb_done, wb_id, wb_rd, busy
   );

endinterface
`default_nettype wire

// File: rtl/pipelined_alu_unit_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipelined_alu_unit_stage : one valid/data register of the result pipe |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module pipelined_alu_unit_stage #(
   parameter type T = logic
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic i_flush,
   input  wire logic i_load,
   input  wire logic i_valid,
   input  wire T     i_data,
   output logic      o_valid,
   output T          o_data
);

   logic r_valid;
   T     r_data;

   // Data is captured only with a valid source so a held result never changes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         if (i_flush) begin
            r_valid <= 1'b0;
         end else if (i_load) begin
            r_valid <= i_valid;
         end
         if (i_load && i_valid) begin
            r_data <= i_data;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pipelined_alu_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipelined_alu_unit : RV32I/RV64I integer ALU with LATENCY-deep result |
// | pipe and valid/ack writeback. Revision 1.0                            |
// +-----------------------------------------------------------------------+
module pipelined_alu_unit
   import pipelined_alu_unit_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int LATENCY = c_alu_latency,
   parameter int ID_W    = 3
) (
   input wire logic             clk,
   input wire logic             rst,
   pipelined_alu_unit_if.slave  bus
);

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [XLEN-1:0] result;
   } alu_pipe_entry_t;

   logic            w_sub;
   logic [XLEN-1:0] w_b;
   logic [XLEN:0]   w_sum;
   logic            w_lt_u;
   logic            w_lt_s;
   logic [XLEN-1:0] w_sll;
   logic [XLEN-1:0] w_srl;
   logic [XLEN-1:0] w_sra;
   logic [XLEN-1:0] w_result;

   assign w_sub = alu_op_uses_sub(bus.op);
   assign w_b   = w_sub ? ~bus.in2 : bus.in2;
   assign w_sum = {1'b0, bus.in1} + {1'b0, w_b} + {{XLEN{1'b0}}, w_sub};

   // No carry out of in1 + ~in2 + 1 means in1 < in2 unsigned.
   assign w_lt_u = ~w_sum[XLEN];
   assign w_lt_s = (bus.in1[XLEN-1] != bus.in2[XLEN-1]) ? bus.in1[XLEN-1] : w_sum[XLEN-1];

   assign w_sll = bus.in1 << bus.shamt;
   assign w_srl = bus.in1 >> bus.shamt;
   assign w_sra = $signed(bus.in1) >>> bus.shamt;

   always_comb begin
      w_result = '0;
      case (bus.op)
         ALU_ADD,
         ALU_SUB:  w_result = w_sum[XLEN-1:0];
         ALU_XOR:  w_result = bus.in1 ^ bus.in2;
         ALU_OR:   w_result = bus.in1 | bus.in2;
         ALU_AND:  w_result = bus.in1 & bus.in2;
         ALU_SLT:  w_result = {{(XLEN-1){1'b0}}, w_lt_s};
         ALU_SLTU: w_result = {{(XLEN-1){1'b0}}, w_lt_u};
         ALU_SLL:  w_result = w_sll;
         ALU_SRL:  w_result = w_srl;
         ALU_SRA:  w_result = w_sra;
         default:  w_result = '0;
      endcase
   end

   // Index 0 is the issue transfer; 1..LATENCY are the registered stages.
   logic            w_stage_valid [0:LATENCY];
   alu_pipe_entry_t w_stage_data  [0:LATENCY];
   logic            w_move        [1:LATENCY];
   logic            w_take;
   logic            w_busy;

   // A stage may load when it is empty or everything downstream drains.
   always_comb begin
      w_take = bus.wb_ack;
      for (int k = LATENCY; k >= 1; k--) begin
         w_take    = ~w_stage_valid[k] | w_take;
         w_move[k] = w_take;
      end
   end

   assign w_stage_valid[0]       = bus.issue_valid & w_move[1];
   assign w_stage_data[0].id     = bus.issue_id;
   assign w_stage_data[0].result = w_result;

   generate
      for (genvar k = 1; k <= LATENCY; k++) begin : g_stage
         pipelined_alu_unit_stage #(
            .T (alu_pipe_entry_t)
         ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_flush (bus.flush),
            .i_load  (w_move[k]),
            .i_valid (w_stage_valid[k-1]),
            .i_data  (w_stage_data[k-1]),
            .o_valid (w_stage_valid[k]),
            .o_data  (w_stage_data[k])
         );
      end
   endgenerate

   always_comb begin
      w_busy = 1'b0;
      for (int k = 1; k <= LATENCY; k++) begin
         w_busy = w_busy | w_stage_valid[k];
      end
   end

   assign bus.issue_ready = w_move[1];
   assign bus.wb_done     = w_stage_valid[LATENCY];
   assign bus.wb_id       = w_stage_data[LATENCY].id;
   assign bus.wb_rd       = w_stage_data[LATENCY].result;
   assign bus.busy        = w_busy;

endmodule
`default_nettype wire
